// File: rtl/sobel_window.sv
// Streaming 3x3 Sobel edge detector with a fixed three-stage pipeline (window, gradients, magnitude).
// Define SOBEL_THRESHOLD_EN to binarize the magnitude against the threshold input instead.
module sobel_window #(
    parameter int ROW_SIZE   = 1280,
    parameter int NUM_ROWS   = 960,
    parameter int PIXEL_SIZE = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  sof,
    input  logic [PIXEL_SIZE-1:0] pixel,
    input  logic [PIXEL_SIZE-1:0] row1_pixel,
    input  logic [PIXEL_SIZE-1:0] row2_pixel,
    input  logic [PIXEL_SIZE-1:0] threshold,
    output logic                  out_valid,
    output logic [PIXEL_SIZE-1:0] edge_pixel
);

    localparam int COL_W  = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int GRAD_W = PIXEL_SIZE + 3;
    localparam int MAG_W  = PIXEL_SIZE + 4;

    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [PIXEL_SIZE-1:0] PIX_MAX  = {PIXEL_SIZE{1'b1}};
    localparam logic [MAG_W-1:0]      MAG_SAT  = {4'b0000, PIX_MAX};

    // 1-2-1 weighted sum of three unsigned pixels, widened so the difference of two sums cannot overflow.
    function automatic logic signed [GRAD_W-1:0] weigh(
        input logic [PIXEL_SIZE-1:0] a,
        input logic [PIXEL_SIZE-1:0] b,
        input logic [PIXEL_SIZE-1:0] c
    );
        logic signed [GRAD_W-1:0] ea;
        logic signed [GRAD_W-1:0] eb;
        logic signed [GRAD_W-1:0] ec;
        ea = signed'({3'b000, a});
        eb = signed'({3'b000, b});
        ec = signed'({3'b000, c});
        return ea + (eb <<< 1) + ec;
    endfunction

    function automatic logic [MAG_W-1:0] abs_ext(input logic signed [GRAD_W-1:0] g);
        logic signed [MAG_W-1:0] wide;
        wide = MAG_W'(g);
        return wide[MAG_W-1] ? unsigned'(-wide) : unsigned'(wide);
    endfunction

    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;

    // win_q[column][row]: column 0 is the oldest (left), row 0 the oldest (top).
    logic [PIXEL_SIZE-1:0] win_q [3][3];
    logic [PIXEL_SIZE-1:0] win_d [3][3];
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_border_q, s1_border_d;

    logic signed [GRAD_W-1:0] gx_q, gx_d;
    logic signed [GRAD_W-1:0] gy_q, gy_d;
    logic                     s2_valid_q, s2_valid_d;
    logic                     s2_border_q, s2_border_d;

    logic [MAG_W-1:0]      mag;
    logic [PIXEL_SIZE-1:0] level;
    logic                  out_valid_q, out_valid_d;
    logic [PIXEL_SIZE-1:0] edge_q, edge_d;

    // sof overrides the counters so a frame can restart from any position.
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        if (in_valid && sof) begin
            cur_col = '0;
            cur_row = '0;
        end
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        win_d       = win_q;
        s1_valid_d  = in_valid;
        s1_border_d = s1_border_q;
        if (in_valid) begin
            win_d[0]    = win_q[1];
            win_d[1]    = win_q[2];
            win_d[2][0] = row2_pixel;
            win_d[2][1] = row1_pixel;
            win_d[2][2] = pixel;
            s1_border_d = (int'(cur_col) < 2) || (int'(cur_row) < 2);
        end
    end

    always_comb begin
        gx_d        = gx_q;
        gy_d        = gy_q;
        s2_valid_d  = s1_valid_q;
        s2_border_d = s2_border_q;
        if (s1_valid_q) begin
            gx_d = weigh(win_q[2][0], win_q[2][1], win_q[2][2])
                 - weigh(win_q[0][0], win_q[0][1], win_q[0][2]);
            gy_d = weigh(win_q[0][2], win_q[1][2], win_q[2][2])
                 - weigh(win_q[0][0], win_q[1][0], win_q[2][0]);
            s2_border_d = s1_border_q;
        end
    end

`ifndef SOBEL_THRESHOLD_EN
    logic unused_threshold;
    assign unused_threshold = ^threshold;
`endif

    always_comb begin
        mag = abs_ext(gx_q) + abs_ext(gy_q);
`ifdef SOBEL_THRESHOLD_EN
        level = (mag >= {4'b0000, threshold}) ? PIX_MAX : '0;
`else
        level = (mag > MAG_SAT) ? PIX_MAX : mag[PIXEL_SIZE-1:0];
`endif
        out_valid_d = s2_valid_q;
        edge_d      = edge_q;
        if (s2_valid_q) begin
            edge_d = s2_border_q ? '0 : level;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            s1_valid_q  <= 1'b0;
            s1_border_q <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            s2_valid_q  <= 1'b0;
            s2_border_q <= 1'b0;
            out_valid_q <= 1'b0;
            edge_q      <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            s1_valid_q  <= s1_valid_d;
            s1_border_q <= s1_border_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            s2_valid_q  <= s2_valid_d;
            s2_border_q <= s2_border_d;
            out_valid_q <= out_valid_d;
            edge_q      <= edge_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign edge_pixel = edge_q;

endmodule

// File: tb/tb_sobel_window.sv
// Bench for sobel_window: pattern-generated frames, expected edges queued at drive time and
// compared when out_valid is due three cycles later.
module tb_sobel_window;

    localparam int ROW_SIZE   = 8;
    localparam int NUM_ROWS   = 6;
    localparam int PIXEL_SIZE = 12;
    localparam int FRAME      = ROW_SIZE * NUM_ROWS;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  sof;
    logic [PIXEL_SIZE-1:0] pixel;
    logic [PIXEL_SIZE-1:0] row1_pixel;
    logic [PIXEL_SIZE-1:0] row2_pixel;
    logic [PIXEL_SIZE-1:0] threshold;
    logic                  out_valid;
    logic [PIXEL_SIZE-1:0] edge_pixel;

    sobel_window #(
        .ROW_SIZE  (ROW_SIZE),
        .NUM_ROWS  (NUM_ROWS),
        .PIXEL_SIZE(PIXEL_SIZE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .sof       (sof),
        .pixel     (pixel),
        .row1_pixel(row1_pixel),
        .row2_pixel(row2_pixel),
        .threshold (threshold),
        .out_valid (out_valid),
        .edge_pixel(edge_pixel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                    due;
        logic [PIXEL_SIZE-1:0] value;
    } sb_t;

    sb_t sb[$];
    sb_t exp_e;
    bit  exp_v;

    int mode;
    int hi;
    int seed;
    int errors = 0;
    int checks = 0;

    logic                  obs_valid;
    logic [PIXEL_SIZE-1:0] obs_pixel;
    int                    obs_cyc;

    // Image content as a pure function of position; row/column may be negative for the unused top rows.
    function automatic int pat(input int r, input int c);
        case (mode)
            0:       return hi;
            1:       return (c >= 4) ? hi : 0;
            2:       return (r >= 3) ? hi : 0;
            4:       return (c < 4) ? hi : 0;
            default: return (((r * 7919 + c * 104729 + seed) % 4096) + 4096) % 4096;
        endcase
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [PIXEL_SIZE-1:0] expect_edge(input int r, input int c);
        int gx, gy, mag;
        if (r < 2 || c < 2) return '0;
        gx = (pat(r-2, c) + 2*pat(r-1, c) + pat(r, c))
           - (pat(r-2, c-2) + 2*pat(r-1, c-2) + pat(r, c-2));
        gy = (pat(r, c-2) + 2*pat(r, c-1) + pat(r, c))
           - (pat(r-2, c-2) + 2*pat(r-2, c-1) + pat(r-2, c));
        mag = iabs(gx) + iabs(gy);
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= int'(threshold)) ? 12'hFFF : 12'h000;
`else
        return (mag > 4095) ? 12'hFFF : PIXEL_SIZE'(mag);
`endif
    endfunction

    task automatic drive(input bit v, input bit s, input int r, input int c);
        sb_t e;
        in_valid = v;
        sof      = s;
`ifndef SOBEL_THRESHOLD_EN
        threshold = PIXEL_SIZE'($urandom);
`endif
        if (v) begin
            pixel      = PIXEL_SIZE'(pat(r, c));
            row1_pixel = PIXEL_SIZE'(pat(r - 1, c));
            row2_pixel = PIXEL_SIZE'(pat(r - 2, c));
            e.due   = cyc + 3;
            e.value = expect_edge(r, c);
            sb.push_back(e);
        end else begin
            pixel      = PIXEL_SIZE'($urandom);
            row1_pixel = PIXEL_SIZE'($urandom);
            row2_pixel = PIXEL_SIZE'($urandom);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        obs_valid = out_valid;
        obs_pixel = edge_pixel;
        obs_cyc   = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        sof      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (obs_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid cyc=%0d got=%b want=0", obs_cyc, obs_valid);
            end
            checks++;
            if (obs_pixel !== '0) begin
                errors++;
                $display("[TB] FAIL reset_pixel cyc=%0d got=%0d want=0", obs_cyc, obs_pixel);
            end
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_uniform;
        int pulses = 0;
        mode = 0;
        hi   = 100;
        for (int k = 0; k < FRAME + 4; k++) begin
            if (k < FRAME) drive(1'b1, k == 0, k / ROW_SIZE, k % ROW_SIZE);
            else           drive(1'b0, 1'b0, 0, 0);
            tick;
            if (obs_valid === 1'b1) pulses++;
            exp_v = (sb.size() != 0) && (sb[0].due == obs_cyc);
            checks++;
            if (obs_valid !== exp_v) begin
                errors++;
                $display("[TB] FAIL uniform_valid cyc=%0d got=%b want=%b", obs_cyc, obs_valid, exp_v);
            end
            if (exp_v) begin
                exp_e = sb.pop_front();
                checks++;
                if (obs_pixel !== exp_e.value) begin
                    errors++;
                    $display("[TB] FAIL uniform_pixel cyc=%0d got=%0d want=%0d", obs_cyc, obs_pixel, exp_e.value);
                end
            end
        end
        checks++;
        if (pulses != FRAME) begin
            errors++;
            $display("[TB] FAIL uniform_pulses got=%0d want=%0d", pulses, FRAME);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL uniform_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // Rising and falling vertical steps plus a horizontal step, at a given amplitude.
    task automatic test_steps(input int amp);
        hi = amp;
        for (int m = 0; m < 3; m++) begin
            mode = (m == 0) ? 1 : ((m == 1) ? 4 : 2);
            for (int k = 0; k < FRAME + 4; k++) begin
                if (k < FRAME) drive(1'b1, k == 0, k / ROW_SIZE, k % ROW_SIZE);
                else           drive(1'b0, 1'b0, 0, 0);
                tick;
                exp_v = (sb.size() != 0) && (sb[0].due == obs_cyc);
                checks++;
                if (obs_valid !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL step_valid amp=%0d mode=%0d cyc=%0d got=%b want=%b", amp, mode, obs_cyc, obs_valid, exp_v);
                end
                if (exp_v) begin
                    exp_e = sb.pop_front();
                    checks++;
                    if (obs_pixel !== exp_e.value) begin
                        errors++;
                        $display("[TB] FAIL step_pixel amp=%0d mode=%0d cyc=%0d got=%0d want=%0d", amp, mode, obs_cyc, obs_pixel, exp_e.value);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL step_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // Every other cycle idle, with sof raised on the idle cycles where it must be ignored.
    task automatic test_gaps;
        int idx;
        mode = 1;
        hi   = 1000;
        for (int k = 0; k < 2 * FRAME + 4; k++) begin
            idx = k / 2;
            if (k < 2 * FRAME && (k % 2) == 0) drive(1'b1, k == 0, idx / ROW_SIZE, idx % ROW_SIZE);
            else                               drive(1'b0, 1'b1, 0, 0);
            tick;
            exp_v = (sb.size() != 0) && (sb[0].due == obs_cyc);
            checks++;
            if (obs_valid !== exp_v) begin
                errors++;
                $display("[TB] FAIL gaps_valid cyc=%0d got=%b want=%b", obs_cyc, obs_valid, exp_v);
            end
            if (exp_v) begin
                exp_e = sb.pop_front();
                checks++;
                if (obs_pixel !== exp_e.value) begin
                    errors++;
                    $display("[TB] FAIL gaps_pixel cyc=%0d got=%0d want=%0d", obs_cyc, obs_pixel, exp_e.value);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL gaps_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // A frame abandoned after 13 pixels and restarted by sof.
    task automatic test_sof_restart;
        int idx;
        mode = 3;
        seed = 17;
        for (int k = 0; k < 13 + FRAME + 4; k++) begin
            idx = (k < 13) ? k : k - 13;
            if (k < 13 + FRAME) drive(1'b1, (k == 0) || (k == 13), idx / ROW_SIZE, idx % ROW_SIZE);
            else                drive(1'b0, 1'b0, 0, 0);
            tick;
            exp_v = (sb.size() != 0) && (sb[0].due == obs_cyc);
            checks++;
            if (obs_valid !== exp_v) begin
                errors++;
                $display("[TB] FAIL sof_valid cyc=%0d got=%b want=%b", obs_cyc, obs_valid, exp_v);
            end
            if (exp_v) begin
                exp_e = sb.pop_front();
                checks++;
                if (obs_pixel !== exp_e.value) begin
                    errors++;
                    $display("[TB] FAIL sof_pixel cyc=%0d got=%0d want=%0d", obs_cyc, obs_pixel, exp_e.value);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sof_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // Two frames at full rate; the second relies on the row counter wrapping without sof.
    task automatic test_back_to_back;
        int idx;
        mode = 3;
        seed = 911;
        for (int k = 0; k < 2 * FRAME + 4; k++) begin
            idx = k % FRAME;
            if (k < 2 * FRAME) drive(1'b1, k == 0, idx / ROW_SIZE, idx % ROW_SIZE);
            else               drive(1'b0, 1'b0, 0, 0);
            tick;
            exp_v = (sb.size() != 0) && (sb[0].due == obs_cyc);
            checks++;
            if (obs_valid !== exp_v) begin
                errors++;
                $display("[TB] FAIL b2b_valid cyc=%0d got=%b want=%b", obs_cyc, obs_valid, exp_v);
            end
            if (exp_v) begin
                exp_e = sb.pop_front();
                checks++;
                if (obs_pixel !== exp_e.value) begin
                    errors++;
                    $display("[TB] FAIL b2b_pixel cyc=%0d got=%0d want=%0d", obs_cyc, obs_pixel, exp_e.value);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // One reset cycle at row 3 column 5, then a new frame with no sof.
    task automatic test_reset_mid_frame;
        int idx;
        mode = 3;
        seed = 4242;
        for (int k = 0; k < 30 + FRAME + 4; k++) begin
            rst_n = (k != 29);
            if (k < 29) begin
                drive(1'b1, k == 0, k / ROW_SIZE, k % ROW_SIZE);
            end else if (k == 29) begin
                drive(1'b0, 1'b0, 0, 0);
                in_valid = 1'b1;
            end else if (k < 30 + FRAME) begin
                idx = k - 30;
                drive(1'b1, 1'b0, idx / ROW_SIZE, idx % ROW_SIZE);
            end else begin
                drive(1'b0, 1'b0, 0, 0);
            end
            tick;
            exp_v = (sb.size() != 0) && (sb[0].due == obs_cyc);
            checks++;
            if (obs_valid !== exp_v) begin
                errors++;
                $display("[TB] FAIL midrst_valid cyc=%0d got=%b want=%b", obs_cyc, obs_valid, exp_v);
            end
            if (exp_v) begin
                exp_e = sb.pop_front();
                checks++;
                if (obs_pixel !== exp_e.value) begin
                    errors++;
                    $display("[TB] FAIL midrst_pixel cyc=%0d got=%0d want=%0d", obs_cyc, obs_pixel, exp_e.value);
                end
            end
            if (k == 29) sb.delete();
            if (k == 30) begin
                checks++;
                if (obs_pixel !== '0) begin
                    errors++;
                    $display("[TB] FAIL midrst_cleared cyc=%0d got=%0d want=0", obs_cyc, obs_pixel);
                end
            end
        end
        rst_n = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL midrst_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

`ifdef SOBEL_THRESHOLD_EN
    task automatic test_threshold;
        mode = 1;
        hi   = 1000;
        for (int t = 0; t < 2; t++) begin
            threshold = (t == 0) ? 12'd2000 : 12'd4001;
            for (int k = 0; k < FRAME + 4; k++) begin
                if (k < FRAME) drive(1'b1, k == 0, k / ROW_SIZE, k % ROW_SIZE);
                else           drive(1'b0, 1'b0, 0, 0);
                tick;
                exp_v = (sb.size() != 0) && (sb[0].due == obs_cyc);
                checks++;
                if (obs_valid !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL thr_valid thr=%0d cyc=%0d got=%b want=%b", threshold, obs_cyc, obs_valid, exp_v);
                end
                if (exp_v) begin
                    exp_e = sb.pop_front();
                    checks++;
                    if (obs_pixel !== exp_e.value) begin
                        errors++;
                        $display("[TB] FAIL thr_pixel thr=%0d cyc=%0d got=%0d want=%0d", threshold, obs_cyc, obs_pixel, exp_e.value);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL thr_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        sof        = 1'b0;
        pixel      = '0;
        row1_pixel = '0;
        row2_pixel = '0;
        threshold  = '0;
        mode       = 0;
        hi         = 0;
        seed       = 0;
        @(posedge clk);
        #1;
        test_reset;
        test_uniform;
        test_steps(1000);
        test_steps(4095);
        test_gaps;
        test_sof_restart;
        test_back_to_back;
        test_reset_mid_frame;
`ifdef SOBEL_THRESHOLD_EN
        test_threshold;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
